// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants, lane word helpers and feeder state encoding.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package tmds_pkg;

    localparam int SYM_W         = 10;
    localparam int SYMS_PER_WORD = 4;
    localparam int NUM_LANES     = 4;
    localparam int NUM_CH        = 3;
    localparam int LANE_W        = SYM_W * SYMS_PER_WORD;
    localparam int BEAT_W        = SYM_W * NUM_CH * SYMS_PER_WORD;
    localparam int TX_W          = LANE_W * NUM_LANES;

    // Control-period symbol (C1C0 = 00) and the TMDS clock pattern symbol.
    localparam logic [SYM_W-1:0]  IDLE_SYM  = 10'h354;
    localparam logic [SYM_W-1:0]  CLK_SYM   = 10'h01F;
    localparam logic [LANE_W-1:0] IDLE_WORD = {SYMS_PER_WORD{IDLE_SYM}};
    localparam logic [LANE_W-1:0] CLK_WORD  = {SYMS_PER_WORD{CLK_SYM}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } feeder_state_t;

    // Gather the four pixel symbols of one channel into a lane word, pixel 0 in the LSBs.
    function automatic logic [LANE_W-1:0] channel_word(input logic [BEAT_W-1:0] beat, input int ch);
        logic [LANE_W-1:0] w;
        w = '0;
        for (int p = 0; p < SYMS_PER_WORD; p++) begin
            w[SYM_W*p +: SYM_W] = beat[SYM_W*NUM_CH*p + SYM_W*ch +: SYM_W];
        end
        return w;
    endfunction

    // Full transceiver word with every data lane idle and the clock pattern on clock_lane.
    function automatic logic [TX_W-1:0] idle_lanes(input int clock_lane);
        logic [TX_W-1:0] w;
        w = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w[LANE_W*l +: LANE_W] = (l == clock_lane) ? CLK_WORD : IDLE_WORD;
        end
        return w;
    endfunction

endpackage

// File: rtl/tmds_sync_fifo.sv
// Single-clock FIFO for TMDS beats with wrap-bit pointers and a synchronous clear.
// Latency: pushed word visible at pop_data the cycle after the push; pop_data is a combinational read.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module tmds_sync_fifo #(
    parameter int WIDTH      = 120,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty after wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate every read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/tmds_lane_feeder.sv
// Elastic feeder from 4-pixel TMDS beats to the 4-lane 160-bit transceiver word; optional TMDS_LANE_INVERT_EN adds per-lane P/N inversion.
// Latency: beat popped in cycle t is on tx_data in t+1; first beat out PREFILL+2 cycles after acceptance when streamed back-to-back.
// Backpressure: in_ready = enable && FIFO not full (registered occupancy); on underflow idle symbols are sent and the FIFO refills to PREFILL.
module tmds_lane_feeder
    import tmds_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8,
    parameter int CLOCK_LANE = 3
) (
    input  logic               clock,
    input  logic               reset,
`ifdef TMDS_LANE_INVERT_EN
    input  logic [3:0]         lane_invert,
`endif
    input  logic               enable,
    input  logic [BEAT_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [TX_W-1:0]    tx_data,
    output logic               running,
    output logic               underflow,
    output logic [15:0]        underflow_count
);

    localparam logic [TX_W-1:0]       IDLE_LANES  = idle_lanes(CLOCK_LANE);
    localparam logic [DEPTH_LOG2:0]   PREFILL_CNT = PREFILL[DEPTH_LOG2:0];

    feeder_state_t       state;
    feeder_state_t       state_nxt;
    logic [BEAT_W-1:0]   fifo_dat;
    logic [DEPTH_LOG2:0] fifo_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                load_beat;
    logic                starve;
    logic [TX_W-1:0]     lanes_nxt;
    logic [TX_W-1:0]     tx_q;

    assign in_ready  = enable && !fifo_full;
    assign load_beat = enable && (state == ST_RUN) && !fifo_empty;
    assign starve    = enable && (state == ST_RUN) && fifo_empty;
    assign running   = (state == ST_RUN);

    // Dropping enable clears the FIFO, so IDLE always starts from empty.
    tmds_sync_fifo #(
        .WIDTH      (BEAT_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (!enable),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (load_beat),
        .pop_data  (fifo_dat),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state: enable low always returns to IDLE; RUN falls back to FILL on starvation.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_FILL;
                ST_FILL: if (fifo_cnt >= PREFILL_CNT) state_nxt = ST_RUN;
                ST_RUN:  if (fifo_empty) state_nxt = ST_FILL;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Lane mapping: channels fill the non-clock lanes in ascending order; anything else sends idle.
    always_comb begin
        lanes_nxt = IDLE_LANES;
        if (load_beat) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (l != CLOCK_LANE) begin
                    lanes_nxt[LANE_W*l +: LANE_W] = channel_word(fifo_dat, (l < CLOCK_LANE) ? l : l - 1);
                end
            end
        end
    end

    // Output word, underflow pulse and saturating underflow counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_q            <= IDLE_LANES;
            underflow       <= 1'b0;
            underflow_count <= 16'h0000;
        end else begin
            tx_q      <= lanes_nxt;
            underflow <= starve;
            if (starve && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 16'h0001;
        end
    end

`ifdef TMDS_LANE_INVERT_EN
    logic [TX_W-1:0] inv_mask;

    // lane_invert is a static board strap, so it is applied after the register; this keeps the reset word inverted as well.
    always_comb begin
        inv_mask = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            inv_mask[LANE_W*l +: LANE_W] = {LANE_W{lane_invert[l]}};
        end
    end

    assign tx_data = tx_q ^ inv_mask;
`else
    assign tx_data = tx_q;
`endif

endmodule

// File: tb/tb_tmds_lane_feeder.sv
// Bench for tmds_lane_feeder: cycle table for fill/run/underflow, scoreboarded data path, hand sequences for corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_tmds_lane_feeder;

    localparam logic [39:0]  IDLE_W = 40'hD5354D5354;
    localparam logic [39:0]  CLK_W  = 40'h07C1F07C1F;
    localparam logic [119:0] IDLE3  = {IDLE_W, IDLE_W, IDLE_W};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         in_valid = 1'b0;
    logic [119:0] in_data = '0;
    logic         in_ready;
    logic [159:0] tx_data;
    logic         running;
    logic         underflow;
    logic [15:0]  underflow_count;

    logic         enable2 = 1'b0;
    logic         in_valid2 = 1'b0;
    logic [119:0] in_data2 = '0;
    logic         in_ready2;
    logic [159:0] tx_data2;
    logic         running2;
    logic         underflow2;
    logic [15:0]  underflow_count2;

`ifdef TMDS_LANE_INVERT_EN
    logic [3:0] lane_invert  = 4'b0000;
    logic [3:0] lane_invert2 = 4'b0001;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int nbeat = 0;
    logic [119:0] sbq[$];

    tmds_lane_feeder u_dut (
        .clock           (clock),
        .reset           (reset),
`ifdef TMDS_LANE_INVERT_EN
        .lane_invert     (lane_invert),
`endif
        .enable          (enable),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .tx_data         (tx_data),
        .running         (running),
        .underflow       (underflow),
        .underflow_count (underflow_count)
    );

    tmds_lane_feeder #(.PREFILL(16)) u_full (
        .clock           (clock),
        .reset           (reset),
`ifdef TMDS_LANE_INVERT_EN
        .lane_invert     (lane_invert2),
`endif
        .enable          (enable2),
        .in_data         (in_data2),
        .in_valid        (in_valid2),
        .in_ready        (in_ready2),
        .tx_data         (tx_data2),
        .running         (running2),
        .underflow       (underflow2),
        .underflow_count (underflow_count2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Beat n: pixel p channel c symbol = {n[5:0], p, c}.
    function automatic logic [119:0] mk_beat(input int n);
        logic [119:0] b;
        logic [5:0]   t;
        t = n[5:0];
        b = '0;
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 3; c++)
                b[30*p + 10*c +: 10] = {t, 2'(p), 2'(c)};
        return b;
    endfunction

    // Expected data lanes 0..2 for a beat: lane c holds channel c, pixel p at [10p +: 10].
    function automatic logic [119:0] exp_lanes(input logic [119:0] b);
        logic [119:0] r;
        r = '0;
        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++)
                r[40*c + 10*p +: 10] = b[30*p + 10*c +: 10];
        return r;
    endfunction

    // Scoreboard: check the output word, then record this cycle's accepted beat.
    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
        end else begin
            chk("clk_lane", tx_data[159:120], CLK_W);
            if (tx_data[119:0] !== IDLE3) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %h, want idle", tx_data[119:0]);
                end else begin
                    chk("beat", tx_data[119:0], exp_lanes(sbq.pop_front()));
                end
            end
            if (!enable) sbq.delete();
            else if (in_valid && in_ready) sbq.push_back(in_data);
        end
    end

    // One cycle: drive at posedge+1, observe {in_ready, running, underflow, data_busy} at negedge.
    task automatic cyc(input logic en, input logic vld, output logic [3:0] obs);
        logic acc;
        enable   = en;
        in_valid = vld;
        in_data  = mk_beat(nbeat);
        @(negedge clock);
        obs = {in_ready, running, underflow, (tx_data[119:0] !== IDLE3)};
        acc = vld && in_ready;
        @(posedge clock);
        #1;
        if (acc) nbeat++;
    endtask

    typedef struct {
        logic       en;
        logic       vld;
        logic [3:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL global_timeout: got running sim, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[21];
        logic [3:0] obs;
        int         cnt;
        int         bad_run;
        bit         seen;
        int         acc2;
        logic       rdy2_hist[18];
        logic       run2_last;

        // Fill-run-underflow table, cycle by cycle from reset release.
        tbl[0] = '{1'b0, 1'b0, 4'b0000};
        for (int i = 1; i <= 8; i++) tbl[i] = '{1'b1, 1'b1, 4'b1000};
        tbl[9]  = '{1'b1, 1'b0, 4'b1000};
        tbl[10] = '{1'b1, 1'b0, 4'b1100};
        for (int i = 11; i <= 18; i++) tbl[i] = '{1'b1, 1'b0, 4'b1101};
        tbl[19] = '{1'b1, 1'b0, 4'b1010};
        tbl[20] = '{1'b1, 1'b0, 4'b1000};

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_tx", tx_data, {CLK_W, IDLE3});
        chk("rst_flags", {in_ready, running, underflow}, 3'b000);
        chk("rst_ucnt", underflow_count, 16'h0000);
`ifdef TMDS_LANE_INVERT_EN
        chk("inv_idle", tx_data2[39:0], 40'h2ACAB2ACAB);
`else
        chk("rst_tx2", tx_data2, {CLK_W, IDLE3});
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table: prefill 8, run out, underflow back to FILL.
        for (int i = 0; i < 21; i++) begin
            cyc(tbl[i].en, tbl[i].vld, obs);
            chk($sformatf("tbl%0d", i), obs, tbl[i].exp);
        end
        chk("tbl_ucnt", underflow_count, 16'd1);
        chk("tbl_sb_empty", sbq.size(), 0);

        // Sustained one beat per cycle.
        cnt = 0;
        bad_run = 0;
        for (int i = 0; i < 1040; i++) begin
            cyc(1'b1, 1'b1, obs);
            if (obs[1]) cnt++;
            if (i >= 12 && obs[3:2] != 2'b11) bad_run++;
        end
        chk("sus_underflows", cnt, 0);
        chk("sus_run_rdy", bad_run, 0);

        // Stop input: drain then one underflow.
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1'b1, 1'b0, obs);
            if (obs[1]) begin
                seen = 1;
                chk("drain_state", obs[2:0], 3'b010);
            end
        end
        chk("drain_uf_seen", seen, 1'b1);
        chk("drain_ucnt", underflow_count, 16'd2);
        chk("drain_sb_empty", sbq.size(), 0);

        // Refill to RUN, leave a few beats queued, then drop enable.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b1, 1'b1, obs);
            seen = obs[2];
        end
        chk("refill_run", seen, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, obs);
        repeat (4) cyc(1'b1, 1'b0, obs);
        cyc(1'b0, 1'b0, obs);
        chk("dis_rdy", obs[3], 1'b0);
        cyc(1'b0, 1'b0, obs);
        chk("dis_out", obs, 4'b0000);
        cyc(1'b0, 1'b0, obs);
        chk("dis_out2", obs, 4'b0000);

        // Re-enable: must restart from an empty FIFO in FILL.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, obs);
            if (obs[2]) cnt++;
        end
        chk("reen_fill", cnt, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b1, 1'b0, obs);
            if (obs[1]) seen = 1;
        end
        chk("reen_uf_seen", seen, 1'b1);
        chk("reen_ucnt", underflow_count, 16'd3);
        chk("reen_sb_empty", sbq.size(), 0);

        // Reset pulse mid-RUN.
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b1, 1'b1, obs);
            seen = obs[2];
        end
        chk("pre_rst_run", seen, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, obs);
        reset = 1'b1;
        #1;
        chk("midrst_tx", tx_data, {CLK_W, IDLE3});
        chk("midrst_flags", {running, underflow}, 2'b00);
        chk("midrst_ucnt", underflow_count, 16'h0000);
        enable   = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, obs);
        chk("post_rst", obs, 4'b0000);

        // Full FIFO on the PREFILL=16 instance.
        acc2 = 0;
        run2_last = 1'b0;
        enable2 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid2 = 1'b1;
            in_data2  = mk_beat(100 + acc2);
            @(negedge clock);
            rdy2_hist[i] = in_ready2;
            run2_last = running2;
            if (in_ready2) acc2++;
            @(posedge clock);
            #1;
        end
        chk("full_accepted", acc2, 16);
        chk("full_rdy15", rdy2_hist[15], 1'b1);
        chk("full_rdy16", rdy2_hist[16], 1'b0);
        chk("full_rdy17_run", {rdy2_hist[17], run2_last}, 2'b01);
        chk("full_uf", underflow2, 1'b0);
        enable2   = 1'b0;
        in_valid2 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("full_ucnt", underflow_count2, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
